microcode_sequencer: RTL

- Parametrised microprogram sequencer for the ARC-style control unit.
- Holds the microPC (uPC) and the registered microinstruction (MIR).
- Drives the control-store address and computes the next address from the MIR COND/JUMP fields, the ALU flags and the IR.
- Stalls on main-memory RD/WR microinstructions through a req/ack handshake. The control store stays an external combinational ROM.

---
 rtl/microcode_sequencer_pkg.sv | 28 ++
 rtl/microcode_sequencer_if.sv | 40 ++++
 rtl/microcode_sequencer_next_addr.sv | 48 ++++
 rtl/microcode_sequencer.sv | 105 ++++++++++
 4 files changed

// File: rtl/microcode_sequencer_pkg.sv
// Shared encodings for the microprogram sequencer: COND field codes, FSM states
// and default microword field positions.
package useq_pkg;

  localparam int DEF_ADDR_W   = 11;
  localparam int DEF_WORD_W   = 41;
  localparam int DEF_RD_BIT   = 19;
  localparam int DEF_WR_BIT   = 18;
  localparam int DEF_COND_LSB = 11;

  typedef enum logic [2:0] {
    COND_NEXT   = 3'b000,
    COND_N      = 3'b001,
    COND_Z      = 3'b010,
    COND_V      = 3'b011,
    COND_C      = 3'b100,
    COND_IR13   = 3'b101,
    COND_JUMP   = 3'b110,
    COND_DECODE = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    ST_FETCH0 = 2'd0,
    ST_RUN    = 2'd1,
    ST_WAIT   = 2'd2
  } state_e;

endpackage

// File: rtl/microcode_sequencer_if.sv
// Sequencer bus: control-store port, IR/flags, memory handshake and status.
// Optional trace outputs exist only when USEQ_TRACE_EN is defined.
interface microcode_sequencer_if #(
  parameter int ADDR_W = 11,
  parameter int WORD_W = 41
);
  logic              uSEQ_Enable_In;
  logic [31:0]       uSEQ_IR_In;
  logic [3:0]        uSEQ_Flags_In;
  logic [WORD_W-1:0] uSEQ_CSData_In;
  logic              uSEQ_MemAck_In;
  logic [ADDR_W-1:0] uSEQ_CSAddr_Out;
  logic [WORD_W-1:0] uSEQ_MIR_Out;
  logic [ADDR_W-1:0] uSEQ_uPC_Out;
  logic              uSEQ_MemReq_Out;
`ifdef USEQ_TRACE_EN
  logic [31:0]       uSEQ_Count_Out;
  logic              uSEQ_Taken_Out;

  modport master (
    input  uSEQ_Enable_In, uSEQ_IR_In, uSEQ_Flags_In, uSEQ_CSData_In, uSEQ_MemAck_In,
    output uSEQ_CSAddr_Out, uSEQ_MIR_Out, uSEQ_uPC_Out, uSEQ_MemReq_Out,
    output uSEQ_Count_Out, uSEQ_Taken_Out
  );
  modport slave (
    output uSEQ_Enable_In, uSEQ_IR_In, uSEQ_Flags_In, uSEQ_CSData_In, uSEQ_MemAck_In,
    input  uSEQ_CSAddr_Out, uSEQ_MIR_Out, uSEQ_uPC_Out, uSEQ_MemReq_Out,
    input  uSEQ_Count_Out, uSEQ_Taken_Out
  );
`else
  modport master (
    input  uSEQ_Enable_In, uSEQ_IR_In, uSEQ_Flags_In, uSEQ_CSData_In, uSEQ_MemAck_In,
    output uSEQ_CSAddr_Out, uSEQ_MIR_Out, uSEQ_uPC_Out, uSEQ_MemReq_Out
  );
  modport slave (
    output uSEQ_Enable_In, uSEQ_IR_In, uSEQ_Flags_In, uSEQ_CSData_In, uSEQ_MemAck_In,
    input  uSEQ_CSAddr_Out, uSEQ_MIR_Out, uSEQ_uPC_Out, uSEQ_MemReq_Out
  );
`endif
endinterface

// File: rtl/microcode_sequencer_next_addr.sv
// Next-address mux: picks uPC+1, the JUMP field or the IR decode address from COND.
// Purely combinational; taken flags any choice other than uPC+1.
module useq_next_addr
  import useq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] upc,
  input  cond_e             cond,
  input  logic [ADDR_W-1:0] jump,
  input  logic [3:0]        flags,
  input  logic              ir13,
  input  logic [1:0]        ir_op,
  input  logic [5:0]        ir_op3,
  output logic [ADDR_W-1:0] na,
  output logic              taken
);

  logic [ADDR_W-1:0] seq_addr;
  logic [ADDR_W-1:0] dec_addr;

  always_comb begin
    seq_addr = upc + ADDR_W'(1);
    // Decode target: top bit set, op in [9:8], op3 in [7:2], word-aligned.
    dec_addr             = '0;
    dec_addr[ADDR_W-1]   = 1'b1;
    dec_addr[9:8]        = ir_op;
    dec_addr[7:2]        = ir_op3;

    taken = 1'b0;
    unique case (cond)
      COND_NEXT:   taken = 1'b0;
      COND_N:      taken = flags[3];
      COND_Z:      taken = flags[2];
      COND_V:      taken = flags[1];
      COND_C:      taken = flags[0];
      COND_IR13:   taken = ir13;
      COND_JUMP:   taken = 1'b1;
      COND_DECODE: taken = 1'b1;
      default:     taken = 1'b0;
    endcase

    na = seq_addr;
    if (cond == COND_DECODE) na = dec_addr;
    else if (taken)          na = jump;
  end

endmodule

// File: rtl/microcode_sequencer.sv
// Microprogram sequencer: uPC/MIR registers, FETCH0/RUN/WAIT FSM, memory req/ack stall.
// Optional trace counter and taken pulse when USEQ_TRACE_EN is defined.
module microcode_sequencer
  import useq_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int WORD_W   = DEF_WORD_W,
  parameter int RD_BIT   = DEF_RD_BIT,
  parameter int WR_BIT   = DEF_WR_BIT,
  parameter int COND_LSB = DEF_COND_LSB
) (
  input  logic uSEQ_CLOCK_50,
  input  logic uSEQ_RESET_InLow,
  microcode_sequencer_if.master bus
);

  state_e            state;
  logic [ADDR_W-1:0] upc;
  logic [WORD_W-1:0] mir;
  logic              mem_req;

  logic [ADDR_W-1:0] na;
  logic              na_taken;
  logic              mem;
  logic              advance;
  logic              en;
  logic              ack;

  assign en  = bus.uSEQ_Enable_In;
  assign ack = bus.uSEQ_MemAck_In;
  assign mem = mir[RD_BIT] | mir[WR_BIT];

  useq_next_addr #(.ADDR_W(ADDR_W)) u_next_addr (
    .upc    (upc),
    .cond   (cond_e'(mir[COND_LSB+2:COND_LSB])),
    .jump   (mir[ADDR_W-1:0]),
    .flags  (bus.uSEQ_Flags_In),
    .ir13   (bus.uSEQ_IR_In[13]),
    .ir_op  (bus.uSEQ_IR_In[31:30]),
    .ir_op3 (bus.uSEQ_IR_In[24:19]),
    .na     (na),
    .taken  (na_taken)
  );

  // An ack arriving with the request gives zero wait states.
  assign advance = en & (((state == ST_RUN) & (~mem | ack)) | ((state == ST_WAIT) & ack));

  always_comb begin
    bus.uSEQ_CSAddr_Out = upc;
    if (state == ST_FETCH0) bus.uSEQ_CSAddr_Out = '0;
    else if (advance)       bus.uSEQ_CSAddr_Out = na;
  end

  always_ff @(posedge uSEQ_CLOCK_50 or negedge uSEQ_RESET_InLow) begin
    if (!uSEQ_RESET_InLow) begin
      state   <= ST_FETCH0;
      upc     <= '0;
      mir     <= '0;
      mem_req <= 1'b0;
    end else if (en) begin
      unique case (state)
        ST_FETCH0: begin
          mir     <= bus.uSEQ_CSData_In;
          upc     <= '0;
          mem_req <= bus.uSEQ_CSData_In[RD_BIT] | bus.uSEQ_CSData_In[WR_BIT];
          state   <= ST_RUN;
        end
        ST_RUN, ST_WAIT: begin
          if (advance) begin
            mir     <= bus.uSEQ_CSData_In;
            upc     <= na;
            mem_req <= bus.uSEQ_CSData_In[RD_BIT] | bus.uSEQ_CSData_In[WR_BIT];
            state   <= ST_RUN;
          end else begin
            state   <= ST_WAIT;
          end
        end
        default: state <= ST_FETCH0;
      endcase
    end
  end

  assign bus.uSEQ_MIR_Out    = mir;
  assign bus.uSEQ_uPC_Out    = upc;
  assign bus.uSEQ_MemReq_Out = mem_req;

`ifdef USEQ_TRACE_EN
  logic [31:0] count;
  logic        taken_q;

  always_ff @(posedge uSEQ_CLOCK_50 or negedge uSEQ_RESET_InLow) begin
    if (!uSEQ_RESET_InLow) begin
      count   <= '0;
      taken_q <= 1'b0;
    end else begin
      taken_q <= advance & na_taken;
      if (advance && (count != 32'hFFFF_FFFF)) count <= count + 32'd1;
    end
  end

  assign bus.uSEQ_Count_Out = count;
  assign bus.uSEQ_Taken_Out = taken_q;
`endif

endmodule
